// File: rtl/fib_pkg.sv
// Shared Fibonacci definitions used by the index classifier and the sequence generator.
//
// Contents:
//   FIB_VALUE_W  - default width of a value under test
//   FIB_IDX_W    - default width of a reported sequence index
//   FIB_MAX_IDX  - largest index representable for FIB_VALUE_W-bit values (F(30) = 832040)
//   fib_state_e  - FSM state encoding shared by the Fibonacci blocks
package fib_pkg;

    localparam int unsigned FIB_VALUE_W = 20;
    localparam int unsigned FIB_IDX_W   = 8;
    localparam int unsigned FIB_MAX_IDX = 30;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSearch = 2'd1,
        StDone   = 2'd2
    } fib_state_e;

endpackage

// File: rtl/fib_step.sv
// Fibonacci term pair: holds consecutive terms a = F(i), b = F(i+1) and steps them forward.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset; returns the pair to (0, 1)
//   load_i     - reload the pair with (F(0), F(1)) = (0, 1)
//   advance_i  - step the pair: a <= b, b <= a + b
//   a_o        - current term F(i)
//   b_o        - next term F(i+1)
module fib_step #(
    parameter int unsigned W = 22
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         advance_i,
    output logic [W-1:0] a_o,
    output logic [W-1:0] b_o
);

    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;

    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (load_i) begin
            a_d = '0;
            b_d = W'(1);
        end else if (advance_i) begin
            a_d = b_q;
            b_d = a_q + b_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= W'(1);
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    assign a_o = a_q;
    assign b_o = b_q;

endmodule

// File: rtl/fibonacci_index.sv
// Fibonacci index classifier: walks the sequence until it meets or passes a captured value and
// reports whether the value is a Fibonacci number plus its (floor) index.
//
// Ports:
//   clk         - clock, rising edge
//   rst         - synchronous active-high reset, priority over start
//   start       - request, accepted only in IDLE
//   value       - number to classify, captured on the accepting edge
//   busy        - high while searching
//   done        - one-cycle pulse, result valid in that cycle
//   is_fib      - 1 when the captured value equals some F(n); held until the next result
//   nth_number  - smallest n with F(n) == value, else k with F(k) < value < F(k+1); held
module fibonacci_index
    import fib_pkg::*;
#(
    parameter int unsigned VALUE_W = FIB_VALUE_W,
    parameter int unsigned IDX_W   = FIB_IDX_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [VALUE_W-1:0] value,
    output logic               busy,
    output logic               done,
    output logic               is_fib,
    output logic [IDX_W-1:0]   nth_number
);

    // Two spare bits so the first term above any VALUE_W value (and the b term beyond it)
    // cannot wrap.
    localparam int unsigned AccW = VALUE_W + 2;

    fib_state_e         state_q;
    logic [VALUE_W-1:0] target_q;
    logic [IDX_W-1:0]   idx_q;
    logic               busy_q;
    logic               done_q;
    logic               is_fib_q;
    logic [IDX_W-1:0]   nth_q;

    logic [AccW-1:0]    a_w;
    logic [AccW-1:0]    b_w;
    logic [AccW-1:0]    target_ext;
    logic               load;
    logic               advance;
    logic               hit;
    logic               over;

    assign target_ext = {2'b00, target_q};
    assign hit        = (a_w == target_ext);
    assign over       = (a_w > target_ext);
    assign load       = (state_q == StIdle) && start;
    assign advance    = (state_q == StSearch) && !hit && !over;

    fib_step #(
        .W (AccW)
    ) u_fib_step (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load),
        .advance_i (advance),
        .a_o       (a_w),
        .b_o       (b_w)
    );

    // b is only consumed inside the step pair; keep it observable for lint.
    logic b_unused;
    assign b_unused = ^b_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            target_q <= '0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            is_fib_q <= 1'b0;
            nth_q    <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (start) begin
                        target_q <= value;
                        idx_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= StSearch;
                    end
                end
                StSearch: begin
                    if (hit) begin
                        is_fib_q <= 1'b1;
                        nth_q    <= idx_q;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= StDone;
                    end else if (over) begin
                        // a = F(idx) already exceeds the target, so the floor index is idx-1;
                        // idx >= 1 here because F(0) = 0 can never exceed the target.
                        is_fib_q <= 1'b0;
                        nth_q    <= idx_q - IDX_W'(1);
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= StDone;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign is_fib     = is_fib_q;
    assign nth_number = nth_q;

endmodule

// File: tb/tb_fibonacci_index.sv
module tb_fibonacci_index;
    import fib_pkg::*;

    localparam int unsigned VW = FIB_VALUE_W;
    localparam int unsigned IW = FIB_IDX_W;
    localparam int          TIMEOUT = 40;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [VW-1:0] value = '0;
    logic          busy;
    logic          done;
    logic          is_fib;
    logic [IW-1:0] nth_number;

    int errors = 0;
    int checks = 0;

    fibonacci_index #(
        .VALUE_W (VW),
        .IDX_W   (IW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .value      (value),
        .busy       (busy),
        .done       (done),
        .is_fib     (is_fib),
        .nth_number (nth_number)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [VW-1:0] value;
        int            edges;
        logic          is_fib;
        int            nth;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Start a search, scribble over value afterwards, wait for done and check everything.
    task automatic run_vec(input vec_t v);
        int    edges;
        int    busy_cnt;
        bit    seen;
        string tag;
        tag   = $sformatf("v=%0d", v.value);
        value = v.value;
        start = 1'b1;
        tick();
        start    = 1'b0;
        value    = ~v.value;
        busy_cnt = busy ? 1 : 0;
        edges    = 0;
        seen     = 1'b0;
        while (!seen && edges < TIMEOUT) begin
            tick();
            edges++;
            if (done) seen = 1'b1;
            else if (busy) busy_cnt++;
        end
        check({tag, " latency"}, edges, v.edges);
        check({tag, " is_fib"}, int'(is_fib), int'(v.is_fib));
        check({tag, " nth"}, int'(nth_number), v.nth);
        check({tag, " busy cycles"}, busy_cnt, v.edges);
        tick();
        check({tag, " done pulse width"}, int'(done), 0);
        check({tag, " busy after done"}, int'(busy), 0);
        check({tag, " is_fib held"}, int'(is_fib), int'(v.is_fib));
        check({tag, " nth held"}, int'(nth_number), v.nth);
    endtask

    initial begin
        int  edges;
        bit  seen;
        bit  busy_seen;

        vecs[0]  = '{value: 20'd0,       edges: 1,  is_fib: 1'b1, nth: 0};
        vecs[1]  = '{value: 20'd1,       edges: 2,  is_fib: 1'b1, nth: 1};
        vecs[2]  = '{value: 20'd2,       edges: 4,  is_fib: 1'b1, nth: 3};
        vecs[3]  = '{value: 20'd3,       edges: 5,  is_fib: 1'b1, nth: 4};
        vecs[4]  = '{value: 20'd4,       edges: 6,  is_fib: 1'b0, nth: 4};
        vecs[5]  = '{value: 20'd6,       edges: 7,  is_fib: 1'b0, nth: 5};
        vecs[6]  = '{value: 20'd100,     edges: 13, is_fib: 1'b0, nth: 11};
        vecs[7]  = '{value: 20'd832040,  edges: 31, is_fib: 1'b1, nth: 30};
        vecs[8]  = '{value: 20'd1048575, edges: 32, is_fib: 1'b0, nth: 30};
        vecs[9]  = '{value: 20'd832039,  edges: 31, is_fib: 1'b0, nth: 29};
        vecs[10] = '{value: 20'd5,       edges: 6,  is_fib: 1'b1, nth: 5};
        vecs[11] = '{value: 20'd144,     edges: 13, is_fib: 1'b1, nth: 12};

        // Reset state.
        rst = 1'b1;
        tick();
        tick();
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset is_fib", int'(is_fib), 0);
        check("reset nth", int'(nth_number), 0);

        // Reset wins over start on the same edge.
        start = 1'b1;
        value = 20'd8;
        tick();
        check("rst+start busy", int'(busy), 0);
        rst   = 1'b0;
        start = 1'b0;
        tick();
        check("rst+start no capture", int'(busy), 0);

        foreach (vecs[i]) begin
            run_vec(vecs[i]);
            if (int'(nth_number) > int'(FIB_MAX_IDX))
                check("nth within max index", int'(nth_number), int'(FIB_MAX_IDX));
        end

        // A second start during a search is ignored.
        value = 20'd832040;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        value = 20'd5;
        tick();
        start = 1'b0;
        value = 20'd0;
        edges = 3;
        seen  = 1'b0;
        while (!seen && edges < TIMEOUT) begin
            tick();
            edges++;
            if (done) seen = 1'b1;
        end
        check("ignored start latency", edges, 31);
        check("ignored start is_fib", int'(is_fib), 1);
        check("ignored start nth", int'(nth_number), 30);
        tick();

        // Control scenario: ignored start, then reset mid-search, then a fresh start.
        value = 20'd832040;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        value = 20'd5;
        tick();
        start = 1'b0;
        tick();
        check("mid-search busy", int'(busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort busy", int'(busy), 0);
        check("abort done", int'(done), 0);
        check("abort is_fib", int'(is_fib), 0);
        check("abort nth", int'(nth_number), 0);
        seen      = 1'b0;
        busy_seen = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            tick();
            if (done) seen = 1'b1;
            if (busy) busy_seen = 1'b1;
        end
        check("abort no done", int'(seen), 0);
        check("abort stays idle", int'(busy_seen), 0);
        run_vec(vecs[10]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
